// File: rtl/riscv_dmem_pipe.sv
// Data-memory request pipeline: ready/valid core bus to a pipelined memory port,
// up to DEPTH requests in flight, in-order responses with lane steering and alignment checks.
module riscv_dmem_pipe #(
  parameter int XLEN  = 64,
  parameter int PLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dmem_req,
  output logic              dmem_rdy,
  input  logic [XLEN-1:0]   dmem_adr,
  input  logic [XLEN-1:0]   dmem_d,
  input  logic              dmem_we,
  input  logic [2:0]        dmem_size,
  output logic              dmem_ack,
  output logic [XLEN-1:0]   dmem_q,
  output logic              dmem_err,
  output logic              dmem_misaligned,
  output logic              mem_req,
  input  logic              mem_ready,
  output logic [PLEN-1:0]   mem_adr,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_d,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_rerr
);

  localparam int BEW   = XLEN / 8;
  localparam int LANEW = $clog2(BEW);
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int TW    = LANEW + 3;

  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             ack_reg;
  logic [XLEN-1:0]  q_reg;
  logic             err_reg;
  logic             mis_reg;
  logic [TW-1:0]    tag_mem [DEPTH];

  logic [LANEW-1:0] lane;
  logic             misaligned;
  logic             not_full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             mis_accept;
  logic [15:0]      be_wide;
  logic [PLEN-1:0]  adr_ext;

  assign lane = dmem_adr[LANEW-1:0];

  always_comb begin
    misaligned = 1'b0;
    case (dmem_size)
      3'd0:    misaligned = 1'b0;
      3'd1:    misaligned = dmem_adr[0];
      3'd2:    misaligned = |dmem_adr[1:0];
      3'd3:    misaligned = (|dmem_adr[2:0]) || (XLEN == 32);
      default: misaligned = 1'b1;
    endcase
  end

  assign not_full   = (count_reg != CW'(DEPTH));
  assign empty      = (count_reg == '0);
  assign mem_req    = dmem_req && !misaligned && not_full;
  assign push       = mem_req && mem_ready;
  // A misaligned request only completes once the pipe is drained, so its ack stays in order.
  assign mis_accept = dmem_req && misaligned && empty && !mis_reg;
  assign pop        = mem_rvalid && !empty;
  assign dmem_rdy   = misaligned ? (empty && !mis_reg) : (mem_ready && not_full);

  generate
    if (PLEN > XLEN) begin : g_adr_ext
      assign adr_ext = {{(PLEN-XLEN){1'b0}}, dmem_adr};
    end else begin : g_adr_trunc
      assign adr_ext = dmem_adr[PLEN-1:0];
    end
  endgenerate

  assign mem_adr = {adr_ext[PLEN-1:LANEW], {LANEW{1'b0}}};
  assign mem_we  = dmem_we;
  assign be_wide = (16'd1 << (5'd1 << dmem_size[1:0])) - 16'd1;
  assign mem_be  = be_wide[BEW-1:0] << lane;
  assign mem_d   = dmem_d << {lane, 3'b000};

  // Tag of each in-flight request: {lane, size, we}
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr_reg] <= {lane, dmem_size[1:0], dmem_we};
    end
  end

  logic [TW-1:0]    head;
  logic [LANEW-1:0] head_lane;
  logic [1:0]       head_size;
  logic             head_we;
  logic [XLEN-1:0]  shifted;
  logic [XLEN-1:0]  size_mask;
  logic [XLEN-1:0]  load_q;

  assign head      = tag_mem[rd_ptr_reg];
  assign head_lane = head[TW-1:3];
  assign head_size = head[2:1];
  assign head_we   = head[0];
  assign shifted   = mem_rdata >> {head_lane, 3'b000};

  always_comb begin
    size_mask = '1;
    case (head_size)
      2'd0:    size_mask = XLEN'(8'hFF);
      2'd1:    size_mask = XLEN'(16'hFFFF);
      2'd2:    size_mask = XLEN'(32'hFFFF_FFFF);
      default: size_mask = '1;
    endcase
  end

  assign load_q = head_we ? '0 : (shifted & size_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ack_reg    <= 1'b0;
      q_reg      <= '0;
      err_reg    <= 1'b0;
      mis_reg    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      // pop and mis_accept are exclusive: a misaligned accept needs an empty pipe.
      ack_reg <= pop || mis_accept;
      err_reg <= pop && mem_rerr;
      mis_reg <= mis_accept;
      q_reg   <= pop ? load_q : '0;
    end
  end

  assign dmem_ack        = ack_reg;
  assign dmem_q          = q_reg;
  assign dmem_err        = err_reg;
  assign dmem_misaligned = mis_reg;

endmodule

// File: doc/riscv_dmem_pipe.md
Name: riscv_dmem_pipe

Overview:
Parametrised data-memory request pipeline between the core's dmem bus and a pipelined memory port. It accepts up to DEPTH outstanding requests and returns responses in order. It also provides:
- alignment checking
- byte-lane steering of store data and byte enables
- right-alignment of load data
It replaces the single-outstanding req/ack dmem handshake with a ready/valid scheme.

Parameters:
XLEN, 64, data/address width (32 or 64)
PLEN, 64, physical address width driven to memory
DEPTH, 4, max outstanding requests (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
dmem_req  in  1  core request valid
dmem_rdy  out  1  request accepted this cycle when dmem_req&&dmem_rdy
dmem_adr  in  XLEN  byte address
dmem_d  in  XLEN  store data, right-aligned
dmem_we  in  1  1=store, 0=load
dmem_size  in  3  0=byte,1=half,2=word,3=dword
dmem_ack  out  1  response valid pulse, one per accepted request
dmem_q  out  XLEN  load data, right-aligned, zero-extended
dmem_err  out  1  bus error for this response
dmem_misaligned  out  1  misaligned/illegal-size response
mem_req  out  1  memory request valid
mem_ready  in  1  memory accepts request when mem_req&&mem_ready
mem_adr  out  PLEN  address with low log2(XLEN/8) bits cleared
mem_we  out  1  store
mem_be  out  XLEN/8  byte enables
mem_d  out  XLEN  lane-steered store data
mem_rvalid  in  1  in-order response for oldest issued request
mem_rdata  in  XLEN  aligned memory word
mem_rerr  in  1  response error

Behaviour:
- Misaligned when any of the following holds:
  - size 1 and adr[0]!=0
  - size 2 and adr[1:0]!=0
  - size 3 and adr[2:0]!=0
  - size 3 with XLEN=32
  - size>3
- Aligned request path (combinational):
  - mem_req=dmem_req&&aligned&&count<DEPTH.
  - dmem_rdy for aligned = mem_ready&&count<DEPTH.
  - mem_adr/mem_we/mem_be/mem_d are combinational from the core inputs.
- Byte enables and store data:
  - mem_be = ((1<<(1<<size))-1) << adr_lane.
  - mem_d = dmem_d << (8*adr_lane), with adr_lane = adr[log2(XLEN/8)-1:0].
- Tag FIFO: on accept, push {adr_lane,size,we} into a DEPTH-entry FIFO with rd/wr pointers and count (0..DEPTH).
- Misaligned request path:
  - Accepted only when count==0 and no misaligned response is pending (dmem_rdy=1); otherwise dmem_rdy=0.
  - No memory request is issued.
  - Next cycle: dmem_ack=1, dmem_misaligned=1, dmem_err=0, dmem_q=0.
- Response path, registered with 1-cycle latency after mem_rvalid:
  - Pop head; dmem_ack=1 next cycle.
  - dmem_err=mem_rerr, dmem_misaligned=0.
  - dmem_q = (mem_rdata >> 8*head.adr_lane) masked to 1<<head.size bytes.
  - For stores, dmem_q=0.
- Simultaneous accept and mem_rvalid: push and pop together, count unchanged; full queue with pop still blocks the new request that cycle (dmem_rdy uses registered count).
- Full (count==DEPTH): dmem_rdy=0, mem_req=0.
- Spurious mem_rvalid with count==0: ignored, no ack, count stays 0.
- mem_ready=0: aligned requests stall (dmem_rdy=0); core holds fields stable.
- Pointer wrap: modulo DEPTH; count distinguishes full/empty.
- Reset (async, any time incl. mid-transaction): pointers=0, count=0, pending misaligned cleared, dmem_ack=0, dmem_q=0, dmem_err=0, dmem_misaligned=0. Outstanding memory responses arriving after reset are dropped per the spurious rule.
- No combinational path from mem_rvalid to dmem_ack.

Test Plan:
- XLEN=64: load size=2, adr=0x1004; mem_rdata=0xAABBCCDD_11223344 -> mem_be=0xF0, mem_adr=0x1000; one cycle after mem_rvalid, dmem_ack=1, dmem_q=0xAABBCCDD.
- Store size=1, adr=0x2006, dmem_d=0x1234 -> mem_be=0xC0, mem_d[63:48]=0x1234, mem_we=1; ack with dmem_q=0, dmem_err=0.
- 4 back-to-back loads with mem_ready=1 and no responses:
  - 5th request sees dmem_rdy=0.
  - On first mem_rvalid, the next request is accepted the following cycle.
  - Acks return in issue order with correct lane data.
- Load size=2, adr=0x3002 with count=0 -> no mem_req; next cycle dmem_ack=1, dmem_misaligned=1. Same request with count=2 -> dmem_rdy=0 until count drains to 0.
- mem_rvalid with mem_rerr=1 for second of three outstanding -> second ack has dmem_err=1, others 0.
- Assert rst with 3 outstanding -> all outputs 0 immediately. Subsequent mem_rvalid pulses produce no dmem_ack, and the next request is accepted at count=0.
